// File: rtl/decode_issue.sv
// decode_issue: ID stage between fetch and the ID/EX boundary.
// Decodes one instruction per cycle, drives the regfile read indices,
// forwards EX/MEM/WB results, inserts one bubble per load-use hazard and
// registers the decoded operands/control into the ID/EX outputs.
//
// Ports:
//   clk, rst                    clock, synchronous active-low reset
//   if_valid/if_ready           fetch handshake (if_ready registered)
//   if_instr/if_pc/if_exception fetched instruction, PC, exception code
//   rf_index_1/2, rf_out_1/2    regfile read indices (comb) and read data
//   ex_*, mem_*, wb_*           forwarding sources, ex_is_load for hazards
//   flush                       redirect: bubble, drop held instruction
//   id_*                        registered ID/EX pipeline outputs
module decode_issue #(
  parameter logic [7:0]  TRAP_STALL_CODE = 8'hFF,
  parameter int unsigned LINK_REG        = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  input  logic [7:0]  if_exception,
  output logic [4:0]  rf_index_1,
  output logic [4:0]  rf_index_2,
  input  logic [31:0] rf_out_1,
  input  logic [31:0] rf_out_2,
  input  logic        ex_wen,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_windex,
  input  logic [31:0] ex_result,
  input  logic        mem_wen,
  input  logic [4:0]  mem_windex,
  input  logic [31:0] mem_result,
  input  logic        wb_wen,
  input  logic [4:0]  wb_windex,
  input  logic [31:0] wb_wdata,
  input  logic        flush,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [5:0]  id_opcode,
  output logic [5:0]  id_funct,
  output logic [31:0] id_op_a,
  output logic [31:0] id_op_b,
  output logic [31:0] id_imm,
  output logic [4:0]  id_windex,
  output logic        id_wen,
  output logic        id_is_load,
  output logic [7:0]  id_exception
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned EW   = 8;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    RUN    = 2'd1,
    STALL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0] hold_instr, hold_pc;
  logic [EW-1:0]   hold_exc;

  logic [XLEN-1:0] src_instr, src_pc;
  logic [EW-1:0]   src_exc;
  logic [5:0]      opcode, funct;
  logic [RW-1:0]   rs, rt, rd;
  logic [15:0]     imm16;
  logic            reads_rt, hazard;
  logic [RW-1:0]   dec_windex;
  logic            dec_wen, dec_is_load;
  logic [XLEN-1:0] dec_imm, fwd_a, fwd_b;
  logic            issue, capture;

  // Decode source: the held instruction while stalled, fetch otherwise.
  always_comb begin
    src_instr = if_instr;
    src_pc    = if_pc;
    src_exc   = if_exception;
    if (state_q == STALL) begin
      src_instr = hold_instr;
      src_pc    = hold_pc;
      src_exc   = hold_exc;
    end
  end

  assign opcode     = src_instr[31:26];
  assign rs         = src_instr[25:21];
  assign rt         = src_instr[20:16];
  assign rd         = src_instr[15:11];
  assign imm16      = src_instr[15:0];
  assign funct      = src_instr[5:0];
  assign rf_index_1 = rs;
  assign rf_index_2 = rt;

  // rt is a true source only for R-type, BEQ, BNE and SW.
  assign reads_rt = (opcode == 6'h00) || (opcode == 6'h04) ||
                    (opcode == 6'h05) || (opcode == 6'h2B);

  // Excepting instructions never wait on a load: they will not execute.
  assign hazard = (src_exc == '0) && ex_is_load && ex_wen && (ex_windex != '0) &&
                  ((ex_windex == rs) || (reads_rt && (ex_windex == rt)));

  // Destination / write enable / immediate.
  always_comb begin
    dec_windex  = '0;
    dec_wen     = 1'b0;
    dec_is_load = (opcode == 6'h23);
    dec_imm     = {{16{imm16[15]}}, imm16};
    if (opcode == 6'h00) begin
      dec_windex = rd;
      dec_wen    = 1'b1;
    end else if (((opcode >= 6'h08) && (opcode <= 6'h0F)) || (opcode == 6'h23)) begin
      dec_windex = rt;
      dec_wen    = 1'b1;
    end else if (opcode == 6'h03) begin
      dec_windex = RW'(LINK_REG);
      dec_wen    = 1'b1;
    end
    if ((opcode >= 6'h0C) && (opcode <= 6'h0E)) begin
      dec_imm = {16'h0000, imm16};
    end else if (opcode == 6'h0F) begin
      dec_imm = {imm16, 16'h0000};
    end
  end

  // Operand A forwarding: EX (non-load) > MEM > WB > regfile; $0 reads 0.
  always_comb begin
    fwd_a = rf_out_1;
    if (rs == '0) begin
      fwd_a = '0;
    end else if (ex_wen && !ex_is_load && (ex_windex == rs)) begin
      fwd_a = ex_result;
    end else if (mem_wen && (mem_windex == rs)) begin
      fwd_a = mem_result;
    end else if (wb_wen && (wb_windex == rs)) begin
      fwd_a = wb_wdata;
    end
  end

  // Operand B forwarding, same priority.
  always_comb begin
    fwd_b = rf_out_2;
    if (rt == '0) begin
      fwd_b = '0;
    end else if (ex_wen && !ex_is_load && (ex_windex == rt)) begin
      fwd_b = ex_result;
    end else if (mem_wen && (mem_windex == rt)) begin
      fwd_b = mem_result;
    end else if (wb_wen && (wb_windex == rt)) begin
      fwd_b = wb_wdata;
    end
  end

  // Next state and issue/capture control; flush overrides everything.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    capture = 1'b0;
    case (state_q)
      WARMUP: state_d = RUN;
      RUN: begin
        if (if_valid) begin
          if (hazard) begin
            capture = 1'b1;
            state_d = STALL;
          end else begin
            issue = 1'b1;
          end
        end
      end
      STALL: begin
        if (!hazard) begin
          issue   = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = WARMUP;
    endcase
    if (flush) begin
      issue   = 1'b0;
      capture = 1'b0;
      state_d = RUN;
    end
  end

  // State, hold register and ID/EX outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= WARMUP;
      if_ready     <= 1'b0;
      hold_instr   <= '0;
      hold_pc      <= '0;
      hold_exc     <= '0;
      id_valid     <= 1'b0;
      id_pc        <= '0;
      id_opcode    <= '0;
      id_funct     <= '0;
      id_op_a      <= '0;
      id_op_b      <= '0;
      id_imm       <= '0;
      id_windex    <= '0;
      id_wen       <= 1'b0;
      id_is_load   <= 1'b0;
      id_exception <= TRAP_STALL_CODE;
    end else begin
      state_q  <= state_d;
      if_ready <= (state_d == RUN);
      if (flush) begin
        hold_instr <= '0;
        hold_pc    <= '0;
        hold_exc   <= '0;
      end else if (capture) begin
        hold_instr <= if_instr;
        hold_pc    <= if_pc;
        hold_exc   <= if_exception;
      end
      if (issue) begin
        id_valid     <= 1'b1;
        id_pc        <= src_pc;
        id_opcode    <= opcode;
        id_funct     <= funct;
        id_op_a      <= fwd_a;
        id_op_b      <= fwd_b;
        id_imm       <= dec_imm;
        id_windex    <= dec_windex;
        id_wen       <= dec_wen && (src_exc == '0);
        id_is_load   <= dec_is_load;
        id_exception <= src_exc;
      end else begin
        id_valid     <= 1'b0;
        id_pc        <= '0;
        id_opcode    <= '0;
        id_funct     <= '0;
        id_op_a      <= '0;
        id_op_b      <= '0;
        id_imm       <= '0;
        id_windex    <= '0;
        id_wen       <= 1'b0;
        id_is_load   <= 1'b0;
        id_exception <= '0;
      end
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// Self-checking bench for decode_issue: expected ID/EX records are queued
// when stimulus is driven and compared one edge later.
module tb_decode_issue;

  localparam logic [7:0] TRAP = 8'hA5;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  windex;
    logic        wen;
    logic        ld;
    logic [7:0]  exc;
  } out_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic [7:0]  if_exception;
  logic [4:0]  rf_index_1, rf_index_2;
  logic [31:0] rf_out_1, rf_out_2;
  logic        ex_wen, ex_is_load;
  logic [4:0]  ex_windex;
  logic [31:0] ex_result;
  logic        mem_wen;
  logic [4:0]  mem_windex;
  logic [31:0] mem_result;
  logic        wb_wen;
  logic [4:0]  wb_windex;
  logic [31:0] wb_wdata;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [5:0]  id_opcode, id_funct;
  logic [31:0] id_op_a, id_op_b, id_imm;
  logic [4:0]  id_windex;
  logic        id_wen, id_is_load;
  logic [7:0]  id_exception;

  logic [31:0] rf_model [32];
  out_t        sb [$];
  int          checks   = 0;
  int          failures = 0;

  decode_issue #(.TRAP_STALL_CODE(TRAP), .LINK_REG(31)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .if_exception(if_exception),
    .rf_index_1(rf_index_1), .rf_index_2(rf_index_2),
    .rf_out_1(rf_out_1), .rf_out_2(rf_out_2),
    .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_windex(ex_windex),
    .ex_result(ex_result),
    .mem_wen(mem_wen), .mem_windex(mem_windex), .mem_result(mem_result),
    .wb_wen(wb_wen), .wb_windex(wb_windex), .wb_wdata(wb_wdata),
    .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_opcode(id_opcode),
    .id_funct(id_funct), .id_op_a(id_op_a), .id_op_b(id_op_b),
    .id_imm(id_imm), .id_windex(id_windex), .id_wen(id_wen),
    .id_is_load(id_is_load), .id_exception(id_exception)
  );

  always #5 clk = ~clk;

  assign rf_out_1 = rf_model[rf_index_1];
  assign rf_out_2 = rf_model[rf_index_2];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic out_t observe();
    return {id_valid, id_pc, id_opcode, id_funct, id_op_a, id_op_b, id_imm,
            id_windex, id_wen, id_is_load, id_exception};
  endfunction

  function automatic out_t mk(input logic [31:0] pc, input logic [31:0] instr,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] imm, input logic [4:0] wi,
                              input logic wen, input logic ld, input logic [7:0] exc);
    out_t o;
    o.valid  = 1'b1;
    o.pc     = pc;
    o.opcode = instr[31:26];
    o.funct  = instr[5:0];
    o.a      = a;
    o.b      = b;
    o.imm    = imm;
    o.windex = wi;
    o.wen    = wen;
    o.ld     = ld;
    o.exc    = exc;
    return o;
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Queue the expectation, advance one edge, compare against the head.
  task automatic step(input string tag, input out_t e);
    out_t x;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check(tag, 160'(observe()), 160'(x));
  endtask

  task automatic idle();
    if_valid = 0; if_instr = '0; if_pc = '0; if_exception = '0;
    ex_wen = 0; ex_is_load = 0; ex_windex = '0; ex_result = '0;
    mem_wen = 0; mem_windex = '0; mem_result = '0;
    wb_wen = 0; wb_windex = '0; wb_wdata = '0;
    flush = 0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] instr);
    if_valid = 1; if_pc = pc; if_instr = instr;
  endtask

  out_t bubble, rstv;
  logic [31:0] instr;

  initial begin
    for (int i = 0; i < 32; i++) rf_model[i] = 32'h1000 + 32'(i);
    rf_model[0] = '0;
    rf_model[2] = 32'h11;
    bubble = '0;
    rstv = '0;
    rstv.exc = TRAP;
    idle();

    // Reset, then one warm-up cycle with if_ready low.
    rst = 0;
    step("reset0", rstv);
    check("ready_reset", 160'(if_ready), 160'(0));
    step("reset1", rstv);
    check("ready_warmup", 160'(if_ready), 160'(0));
    rst = 1;
    step("warmup_bubble", bubble);
    check("ready_run", 160'(if_ready), 160'(1));

    // Forwarding priority: EX beats MEM on rs, WB beats regfile on rt.
    instr = rtype(5'd1, 5'd2, 5'd3, 6'h21);
    issue(32'h100, instr);
    ex_wen = 1; ex_windex = 5'd1; ex_result = 32'hAA;
    mem_wen = 1; mem_windex = 5'd1; mem_result = 32'hBB;
    wb_wen = 1; wb_windex = 5'd2; wb_wdata = 32'hCC;
    #1;
    check("rf_index_1", 160'(rf_index_1), 160'(5'd1));
    check("rf_index_2", 160'(rf_index_2), 160'(5'd2));
    step("fwd_addu", mk(32'h100, instr, 32'hAA, 32'hCC, 32'h1821, 5'd3, 1, 0, 0));

    // Immediate extension variants, back to back.
    idle();
    instr = itype(6'h0D, 5'd0, 5'd4, 16'h8001);
    issue(32'h104, instr);
    step("imm_ori", mk(32'h104, instr, 0, 32'h1004, 32'h00008001, 5'd4, 1, 0, 0));
    instr = itype(6'h09, 5'd0, 5'd4, 16'h8001);
    issue(32'h108, instr);
    step("imm_addiu", mk(32'h108, instr, 0, 32'h1004, 32'hFFFF8001, 5'd4, 1, 0, 0));
    instr = itype(6'h0F, 5'd0, 5'd4, 16'h8001);
    issue(32'h10C, instr);
    step("imm_lui", mk(32'h10C, instr, 0, 32'h1004, 32'h80010000, 5'd4, 1, 0, 0));

    // JAL links into r31; LW marks a load with rt destination.
    instr = {6'h03, 26'h0000010};
    issue(32'h110, instr);
    step("jal", mk(32'h110, instr, 0, 0, 32'h10, 5'd31, 1, 0, 0));
    instr = itype(6'h23, 5'd2, 5'd10, 16'hFFFC);
    issue(32'h114, instr);
    step("lw", mk(32'h114, instr, 32'h11, 32'h100A, 32'hFFFFFFFC, 5'd10, 1, 1, 0));

    // Writes to $0 are never forwarded.
    instr = rtype(5'd0, 5'd0, 5'd7, 6'h21);
    issue(32'h118, instr);
    ex_wen = 1; ex_windex = 5'd0; ex_result = 32'hDEAD;
    step("zero_reg", mk(32'h118, instr, 0, 0, 32'h3821, 5'd7, 1, 0, 0));

    // Load into rt of an instruction that does not read rt: no stall.
    idle();
    instr = itype(6'h0D, 5'd0, 5'd4, 16'h0001);
    issue(32'h11C, instr);
    ex_wen = 1; ex_is_load = 1; ex_windex = 5'd4;
    step("no_hazard_ori", mk(32'h11C, instr, 0, 32'h1004, 32'h1, 5'd4, 1, 0, 0));
    check("ready_no_hazard", 160'(if_ready), 160'(1));

    // Load-use on SW rt: exactly one bubble, then issue from the hold register.
    instr = itype(6'h2B, 5'd6, 5'd5, 16'h0004);
    issue(32'h200, instr);
    ex_windex = 5'd5;
    step("loaduse_bubble", bubble);
    check("ready_stall", 160'(if_ready), 160'(0));
    idle();
    if_instr = 32'hFFFFFFFF;
    mem_wen = 1; mem_windex = 5'd5; mem_result = 32'h1234;
    #1;
    check("stall_rf_index_2", 160'(rf_index_2), 160'(5'd5));
    step("loaduse_issue", mk(32'h200, instr, 32'h1006, 32'h1234, 32'h4, 5'd0, 0, 0, 0));
    check("ready_after_stall", 160'(if_ready), 160'(1));

    // Flush while stalled: held SW is discarded and state returns to RUN.
    idle();
    instr = itype(6'h2B, 5'd6, 5'd5, 16'h0004);
    issue(32'h300, instr);
    ex_wen = 1; ex_is_load = 1; ex_windex = 5'd5;
    step("flush_pre_bubble", bubble);
    check("ready_flush_stall", 160'(if_ready), 160'(0));
    if_valid = 0;
    flush = 1;
    step("flush_bubble", bubble);
    check("ready_after_flush", 160'(if_ready), 160'(1));

    // Excepting instruction issues with wen=0 and ignores a matching EX load.
    idle();
    instr = rtype(5'd9, 5'd9, 5'd8, 6'h21);
    issue(32'h400, instr);
    if_exception = 8'h04;
    ex_wen = 1; ex_is_load = 1; ex_windex = 5'd9;
    step("exception_issue", mk(32'h400, instr, 32'h1009, 32'h1009, 32'h4021, 5'd8, 0, 0, 8'h04));
    check("ready_exception", 160'(if_ready), 160'(1));
    idle();
    step("no_held_replay", bubble);

    // Flush in RUN drops the same-cycle instruction.
    instr = rtype(5'd1, 5'd2, 5'd3, 6'h21);
    issue(32'h500, instr);
    flush = 1;
    step("flush_run_drop", bubble);
    idle();
    step("idle_bubble", bubble);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
